// File: rtl/tour_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tour_cmd_seq
//  Description : Reads solved knight's-tour moves one at a time and turns
//                each into two motion commands (vertical leg, then
//                horizontal leg), handshaking with a command consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tour_cmd_seq #(
  parameter int         NUM_MOVES = 24,
  parameter logic [3:0] OP_MOVE   = 4'h2,
  parameter logic [3:0] OP_FANF   = 4'h3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        busy,
  output logic        tour_done,
  output logic        err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_VERT  = 3'd2;
  localparam logic [2:0] S_WAITV = 3'd3;
  localparam logic [2:0] S_HORZ  = 3'd4;
  localparam logic [2:0] S_WAITH = 3'd5;

  localparam logic [4:0] C_LAST_IDX = 5'(NUM_MOVES - 1);
  localparam logic [7:0] C_HD_N     = 8'h00;
  localparam logic [7:0] C_HD_S     = 8'h7F;
  localparam logic [7:0] C_HD_E     = 8'hBF;
  localparam logic [7:0] C_HD_W     = 8'h3F;

  logic [2:0]  state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic [11:0] horz_q, horz_d;
  logic        tour_done_q, tour_done_d;
  logic        err_q, err_d;

  logic        w_onehot;
  logic [11:0] w_vert_leg;
  logic [11:0] w_horz_leg;

  // Decode the one-hot move into {heading, squares} for each leg; any other
  // pattern (zero or multiple bits) is flagged as not one-hot.
  always_comb begin
    w_onehot   = 1'b1;
    w_vert_leg = 12'h000;
    w_horz_leg = 12'h000;
    case (move)
      8'h01: begin w_vert_leg = {C_HD_N, 4'd2}; w_horz_leg = {C_HD_E, 4'd1}; end
      8'h02: begin w_vert_leg = {C_HD_N, 4'd2}; w_horz_leg = {C_HD_W, 4'd1}; end
      8'h04: begin w_vert_leg = {C_HD_N, 4'd1}; w_horz_leg = {C_HD_W, 4'd2}; end
      8'h08: begin w_vert_leg = {C_HD_S, 4'd1}; w_horz_leg = {C_HD_W, 4'd2}; end
      8'h10: begin w_vert_leg = {C_HD_S, 4'd2}; w_horz_leg = {C_HD_W, 4'd1}; end
      8'h20: begin w_vert_leg = {C_HD_S, 4'd2}; w_horz_leg = {C_HD_E, 4'd1}; end
      8'h40: begin w_vert_leg = {C_HD_S, 4'd1}; w_horz_leg = {C_HD_E, 4'd2}; end
      8'h80: begin w_vert_leg = {C_HD_N, 4'd1}; w_horz_leg = {C_HD_E, 4'd2}; end
      default: w_onehot = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: each leg waits for accept, then for completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_tour)  state_d = S_LOAD;
      S_LOAD:  state_d = w_onehot ? S_VERT : S_IDLE;
      S_VERT:  if (clr_cmd_rdy) state_d = S_WAITV;
      S_WAITV: if (send_resp)   state_d = S_HORZ;
      S_HORZ:  if (clr_cmd_rdy) state_d = S_WAITH;
      S_WAITH: if (send_resp)   state_d = (mv_indx_q == C_LAST_IDX) ? S_IDLE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; the horizontal leg is captured at LOAD so
  // the move input only needs to be valid while its index is being loaded.
  always_comb begin
    mv_indx_d   = mv_indx_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    horz_d      = horz_q;
    tour_done_d = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        mv_indx_d = 5'd0;
      end
      S_LOAD: begin
        if (w_onehot) begin
          cmd_d     = {OP_MOVE, w_vert_leg};
          horz_d    = w_horz_leg;
          cmd_rdy_d = 1'b1;
        end else begin
          err_d     = 1'b1;
          mv_indx_d = 5'd0;
        end
      end
      S_VERT, S_HORZ: begin
        if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
      end
      S_WAITV: begin
        if (send_resp) begin
          cmd_d     = {OP_FANF, horz_q};
          cmd_rdy_d = 1'b1;
        end
      end
      S_WAITH: begin
        if (send_resp) begin
          if (mv_indx_q == C_LAST_IDX) begin
            tour_done_d = 1'b1;
            mv_indx_d   = 5'd0;
          end else begin
            mv_indx_d   = mv_indx_q + 5'd1;
          end
        end
      end
      default: begin
        cmd_rdy_d = 1'b0;
        mv_indx_d = 5'd0;
      end
    endcase
  end

  // Datapath registers; reset aborts any tour without raising a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv_indx_q   <= 5'd0;
      cmd_q       <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
      horz_q      <= 12'h000;
      tour_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mv_indx_q   <= mv_indx_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      horz_q      <= horz_d;
      tour_done_q <= tour_done_d;
      err_q       <= err_d;
    end
  end

  assign mv_indx   = mv_indx_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign busy      = (state_q != S_IDLE);
  assign tour_done = tour_done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tour_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tour_cmd_seq
//  Description : Scoreboard bench for tour_cmd_seq. Expected commands and
//                tour_done/err events are queued as stimulus is issued; a
//                monitor pops and compares whenever the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tour_cmd_seq;

  logic        clk;
  logic        rst;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        busy;
  logic        tour_done;
  logic        err;

  typedef struct packed {
    logic [4:0]  idx;
    logic [15:0] cmd;
  } exp_t;

  exp_t       exp_q[$];
  bit         ev_q[$];       // 1 = tour_done expected, 0 = err expected
  logic [7:0] tbl [0:31];    // solver model: move presented for each index
  int         n_cmp;
  int         n_fail;
  int         rise_cnt;
  logic       prev_rdy;
  logic [15:0] prev_cmd;

  tour_cmd_seq #(
    .NUM_MOVES (24),
    .OP_MOVE   (4'h2),
    .OP_FANF   (4'h3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_tour  (start_tour),
    .move        (move),
    .mv_indx     (mv_indx),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .busy        (busy),
    .tour_done   (tour_done),
    .err         (err)
  );

  assign move = tbl[mv_indx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference: move bit -> (dx,dy) -> heading/squares per leg.
  function automatic logic [15:0] model_cmd(input logic [7:0] mv, input bit horiz);
    int dx, dy, k, d;
    logic [7:0] hd;
    k = 0;
    for (int b = 0; b < 8; b++) if (mv[b]) k = b;
    case (k)
      0: begin dx =  1; dy =  2; end
      1: begin dx = -1; dy =  2; end
      2: begin dx = -2; dy =  1; end
      3: begin dx = -2; dy = -1; end
      4: begin dx = -1; dy = -2; end
      5: begin dx =  1; dy = -2; end
      6: begin dx =  2; dy = -1; end
      default: begin dx = 2; dy = 1; end
    endcase
    if (!horiz) begin
      hd = (dy > 0) ? 8'h00 : 8'h7F;
      d  = (dy < 0) ? -dy : dy;
      return {4'h2, hd, 4'(d)};
    end
    hd = (dx > 0) ? 8'hBF : 8'h3F;
    d  = (dx < 0) ? -dx : dx;
    return {4'h3, hd, 4'(d)};
  endfunction

  task automatic push_cmd(input logic [4:0] idx, input logic [15:0] c);
    exp_t e;
    e.idx = idx;
    e.cmd = c;
    exp_q.push_back(e);
  endtask

  task automatic push_move(input logic [4:0] idx, input logic [7:0] mv);
    push_cmd(idx, model_cmd(mv, 1'b0));
    push_cmd(idx, model_cmd(mv, 1'b1));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 200; i++) begin
      if (cmd_rdy) return;
      step();
    end
    chk("wait_rdy_timeout", 32'(cmd_rdy), 32'd1);
  endtask

  task automatic accept(input int d);
    repeat (d) step();
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic respond(input int d);
    repeat (d) step();
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
  endtask

  // Monitor: score each newly presented command and each done/err pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_rdy && !prev_rdy) begin
        rise_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", 32'(cmd), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cmd_word", 32'(cmd), 32'(e.cmd));
          chk("cmd_mv_indx", 32'(mv_indx), 32'(e.idx));
        end
      end
      if (cmd_rdy && prev_rdy)
        chk("cmd_stable", 32'(cmd), 32'(prev_cmd));
      if (tour_done && err)
        chk("done_err_exclusive", 32'({tour_done, err}), 32'd0);
      if (tour_done || err) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_event", 32'({tour_done, err}), 32'd0);
        end else begin
          bit ev;
          ev = ev_q.pop_front();
          chk("event_kind", 32'({tour_done, err}), ev ? 32'd2 : 32'd1);
        end
      end
    end
    prev_rdy = cmd_rdy;
    prev_cmd = cmd;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0; rise_cnt = 0; prev_rdy = 1'b0; prev_cmd = 16'h0;
    rst = 1'b1; start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    for (int i = 0; i < 32; i++) tbl[i] = 8'h00;

    // Reset values while rst is held.
    repeat (3) step();
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mv_indx", 32'(mv_indx), 32'd0);
    chk("rst_done_err", 32'({tour_done, err}), 32'd0);
    rst = 1'b0;
    step();

    // Move 8'h01, then a zero move at index 1 ends the run with err.
    tbl[0] = 8'h01; tbl[1] = 8'h00;
    push_cmd(5'd0, 16'h2002); push_cmd(5'd0, 16'h3BF1); ev_q.push_back(1'b0);
    pulse_start();
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_cmd_rdy", 32'(cmd_rdy), 32'd0);
    step();
    chk("latency_cmd_rdy", 32'(cmd_rdy), 32'd1);
    send_resp = 1'b1; step(); send_resp = 1'b0;   // early send_resp in VERT
    repeat (2) step();
    chk("early_resp_rdy", 32'(cmd_rdy), 32'd1);
    chk("early_resp_cmd", 32'(cmd), 32'h2002);
    accept(2);
    chk("accept_clears_rdy", 32'(cmd_rdy), 32'd0);
    respond(3);
    clr_cmd_rdy = 1'b1; send_resp = 1'b1; step();  // simultaneous in HORZ
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    repeat (5) step();
    chk("simul_rdy", 32'(cmd_rdy), 32'd0);
    chk("simul_still_waith", 32'({busy, mv_indx}), 32'h20);
    respond(0);
    chk("load_idx1", 32'(mv_indx), 32'd1);
    step();
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_idle", 32'({busy, cmd_rdy, mv_indx}), 32'd0);
    step();
    chk("err_one_cycle", 32'(err), 32'd0);

    // Moves 8'h08, 8'h80, then 8'h03 -> err; start_tour during WAITV ignored.
    tbl[0] = 8'h08; tbl[1] = 8'h80; tbl[2] = 8'h03;
    push_cmd(5'd0, 16'h27F1); push_cmd(5'd0, 16'h33F2);
    push_cmd(5'd1, 16'h2001); push_cmd(5'd1, 16'h3BF2);
    ev_q.push_back(1'b0);
    pulse_start();
    wait_rdy(); accept(0);
    pulse_start();
    repeat (3) step();
    chk("start_in_waitv", 32'({busy, cmd_rdy, mv_indx}), 32'h40);
    respond(1); wait_rdy(); accept(1); respond(0);
    wait_rdy(); accept(4); respond(2);
    wait_rdy(); accept(0); respond(0);
    step();
    chk("err_multi_bit", 32'({err, busy}), 32'd2);
    step();

    // Full tour with random consumer delays.
    begin
      int r0;
      for (int i = 0; i < 24; i++) tbl[i] = 8'h01 << ((i * 3) % 8);
      for (int i = 0; i < 24; i++) push_move(5'(i), tbl[i]);
      ev_q.push_back(1'b1);
      r0 = rise_cnt;
      pulse_start();
      for (int i = 0; i < 24; i++) begin
        wait_rdy();
        chk("tour_mv_indx", 32'(mv_indx), 32'(i));
        accept($urandom_range(0, 20)); respond($urandom_range(0, 20));
        wait_rdy();
        accept($urandom_range(0, 20)); respond($urandom_range(0, 20));
      end
      chk("tour_done_pulse", 32'(tour_done), 32'd1);
      chk("tour_end_idle", 32'({busy, mv_indx}), 32'd0);
      step();
      chk("tour_done_one_cycle", 32'(tour_done), 32'd0);
      repeat (2) step();
      chk("tour_rdy_count", 32'(rise_cnt - r0), 32'd48);
    end

    // Reset mid-WAITH at index 7, then a fresh tour starts at index 0.
    for (int i = 0; i < 24; i++) tbl[i] = 8'h01 << (i % 8);
    for (int i = 0; i < 8; i++) push_move(5'(i), tbl[i]);
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      wait_rdy(); accept(1); respond(1);
      wait_rdy(); accept(1); respond(1);
    end
    wait_rdy(); accept(1); respond(1);
    wait_rdy(); accept(1);
    chk("pre_rst_idx", 32'(mv_indx), 32'd7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cmd", 32'(cmd), 32'h0);
    chk("async_rst_flags", 32'({cmd_rdy, busy, tour_done, err}), 32'd0);
    chk("async_rst_idx", 32'(mv_indx), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();
    chk("no_autostart", 32'(busy), 32'd0);
    tbl[0] = 8'h01; tbl[1] = 8'h00;
    push_cmd(5'd0, 16'h2002); push_cmd(5'd0, 16'h3BF1); ev_q.push_back(1'b0);
    pulse_start();
    wait_rdy();
    chk("post_rst_idx0", 32'(mv_indx), 32'd0);
    accept(0); respond(0); wait_rdy(); accept(0); respond(0);
    repeat (5) step();

    chk("cmds_outstanding", 32'(exp_q.size()), 32'd0);
    chk("events_outstanding", 32'(ev_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
